// File: rtl/gate_sched_pkg.sv
// Shared types and helpers for the gate scheduler.
package gate_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    GATE    = 2'd2,
    HOLDOFF = 2'd3
  } state_e;

  localparam int CW_DEF = 4;

  // A zero-length gate would never be seen downstream, so it is stretched to one cycle.
  function automatic logic [15:0] nz_width(input logic [15:0] w);
    return (w == 16'd0) ? 16'd1 : w;
  endfunction

endpackage

// File: rtl/gate_scheduler_rr_arbiter.sv
// Round-robin pick: first set request after ptr, wrapping modulo NCH.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic           gnt_valid,
  output logic [CHW-1:0] gnt_idx
);

  // Scan ptr+1 .. ptr+NCH; the first hit is the grant.
  always_comb begin
    int idx;
    logic [CHW-1:0] ic;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    ic        = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(ptr) + k) % NCH;
      ic  = CHW'(idx);
      if (!gnt_valid && req[ic]) begin
        gnt_valid = 1'b1;
        gnt_idx   = ic;
      end
    end
  end

endmodule

// File: rtl/gate_scheduler.sv
// Shared gate generator: edge-detected triggers, round-robin grant, delay/gate/holdoff sequencer.
module gate_scheduler
  import gate_sched_pkg::*;
#(
  parameter  int NCH = 4,
  parameter  int CW  = CW_DEF,
  localparam int CHW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] trig,
  input  logic           enable,
  input  logic [CW-1:0]  delay,
  input  logic [CW-1:0]  width,
  input  logic [CW-1:0]  holdoff,
  output logic           gate_out,
  output logic [CHW-1:0] gate_ch,
  output logic           busy,
  output logic [NCH-1:0] pending,
  output logic [NCH-1:0] missed
);

  state_e         state_q, state_d;
  logic [NCH-1:0] trig_q, trig_d;
  logic [NCH-1:0] pending_q, pending_d;
  logic [NCH-1:0] missed_q, missed_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  width_q, width_d;
  logic [CW-1:0]  hold_q, hold_d;
  logic [CHW-1:0] gate_ch_q, gate_ch_d;
  logic [CHW-1:0] rr_ptr_q, rr_ptr_d;

  logic [NCH-1:0] edge_w, gnt_mask;
  logic           gnt_valid, do_grant;
  logic [CHW-1:0] gnt_idx;
  logic [CW-1:0]  width_nz;

  rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
    .req       (pending_q),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Edge detect and pending/missed bookkeeping; a same-cycle edge re-pends a granted channel.
  always_comb begin
    trig_d   = trig;
    edge_w   = trig & ~trig_q;
    do_grant = (state_q == IDLE) && enable && gnt_valid;
    gnt_mask = '0;
    if (do_grant) gnt_mask[gnt_idx] = 1'b1;
    pending_d = (pending_q & ~gnt_mask) | edge_w;
    missed_d  = edge_w & pending_q & ~gnt_mask;
  end

  // Sequencer next state; counters load the phase length and leave the phase when they hit 1.
  always_comb begin
    width_nz  = CW'(nz_width(16'(width)));
    state_d   = state_q;
    cnt_d     = cnt_q;
    width_d   = width_q;
    hold_d    = hold_q;
    gate_ch_d = gate_ch_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (do_grant) begin
          rr_ptr_d  = gnt_idx;
          gate_ch_d = gnt_idx;
          width_d   = width_nz;
          hold_d    = holdoff;
          if (delay != '0) begin
            state_d = DELAY;
            cnt_d   = delay;
          end else begin
            state_d = GATE;
            cnt_d   = width_nz;
          end
        end
      end
      DELAY: begin
        if (cnt_q == CW'(1)) begin
          state_d = GATE;
          cnt_d   = width_q;
        end else cnt_d = cnt_q - CW'(1);
      end
      GATE: begin
        if (cnt_q == CW'(1)) begin
          if (hold_q != '0) begin
            state_d = HOLDOFF;
            cnt_d   = hold_q;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else cnt_d = cnt_q - CW'(1);
      end
      HOLDOFF: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q - CW'(1);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      trig_q    <= '0;
      pending_q <= '0;
      missed_q  <= '0;
      cnt_q     <= '0;
      width_q   <= '0;
      hold_q    <= '0;
      gate_ch_q <= '0;
      rr_ptr_q  <= CHW'(NCH - 1);
    end else begin
      state_q   <= state_d;
      trig_q    <= trig_d;
      pending_q <= pending_d;
      missed_q  <= missed_d;
      cnt_q     <= cnt_d;
      width_q   <= width_d;
      hold_q    <= hold_d;
      gate_ch_q <= gate_ch_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign gate_out = (state_q == GATE);
  assign busy     = (state_q != IDLE);
  assign gate_ch  = gate_ch_q;
  assign pending  = pending_q;
  assign missed   = missed_q;

endmodule

// File: tb/tb_gate_scheduler.sv
// Directed bench for gate_scheduler with a scoreboard of expected gates.
module tb_gate_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] trig = '0;
  logic       enable = 1'b1;
  logic [3:0] delay = '0, width = 4'd1, holdoff = '0;
  logic       gate_out, busy;
  logic [1:0] gate_ch;
  logic [3:0] pending, missed;

  typedef struct { int ch; int len; int start; } exp_t;
  exp_t sb[$];

  int total = 0, bad = 0;
  int cyc = 0;

  gate_scheduler #(.NCH(4), .CW(4)) dut (
    .clk(clk), .rst(rst), .trig(trig), .enable(enable),
    .delay(delay), .width(width), .holdoff(holdoff),
    .gate_out(gate_out), .gate_ch(gate_ch), .busy(busy),
    .pending(pending), .missed(missed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void push(input int ch, input int len, input int start);
    exp_t e;
    e.ch = ch; e.len = len; e.start = start;
    sb.push_back(e);
  endfunction

  // Monitor: measure each completed gate and compare with the scoreboard head.
  logic g_prev = 1'b0;
  int   g_start = 0, g_ch = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) g_prev = 1'b0;
    else begin
      if (gate_out && !g_prev) begin
        g_start = cyc;
        g_ch    = int'(gate_ch);
      end
      if (!gate_out && g_prev) begin
        chk("sb_nonempty", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("gate_ch", g_ch, e.ch);
          chk("gate_len", cyc - g_start, e.len);
          chk("gate_start", g_start, e.start);
        end
      end
      g_prev = gate_out;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input logic [3:0] m, output int c);
    c = cyc;
    trig = trig | m;
    step(1);
    trig = trig & ~m;
  endtask

  task automatic wait_idle(output int c);
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || pending != 4'd0) && n < 300);
    chk("idle_in_budget", int'(n < 300), 1);
    c = cyc;
    step(1);
  endtask

  initial begin
    int c, ic, tmp, m;
    step(3);
    chk("rst_gate_out", int'(gate_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_missed", int'(missed), 0);
    chk("rst_gate_ch", int'(gate_ch), 0);
    rst = 1'b0;
    step(1);

    // Single request through all three phases.
    delay = 4'd3; width = 4'd4; holdoff = 4'd2;
    pulse(4'b0100, c);
    push(2, 4, c + 5);
    chk("t1_pending", int'(pending), 4'b0100);
    wait_idle(ic);
    chk("t1_idle_time", ic, c + 5 + 4 + 2);
    chk("t1_gate_ch_hold", int'(gate_ch), 2);

    // Simultaneous requests served round-robin from channel 0.
    rst = 1'b1; step(1); rst = 1'b0; step(1);
    delay = 4'd0; width = 4'd1; holdoff = 4'd0;
    pulse(4'b1011, c);
    push(0, 1, c + 2); push(1, 1, c + 4); push(3, 1, c + 6);
    wait_idle(ic);

    // Width 0 stretched to 1; full-scale counters without wrap.
    width = 4'd0;
    pulse(4'b0010, c);
    push(1, 1, c + 2);
    wait_idle(ic);
    delay = 4'd15; width = 4'd15; holdoff = 4'd15;
    pulse(4'b0001, c);
    push(0, 15, c + 17);
    wait_idle(ic);
    chk("t3_idle_time", ic, c + 17 + 15 + 15);

    // Re-trigger during own gate: first re-pends, second is missed.
    delay = 4'd0; width = 4'd8; holdoff = 4'd1;
    pulse(4'b0010, c);
    push(1, 8, c + 2); push(1, 8, c + 12);
    step(1);
    pulse(4'b0010, tmp);
    chk("t4_repend", int'(pending), 4'b0010);
    chk("t4_no_miss", int'(missed), 0);
    step(1);
    pulse(4'b0010, tmp);
    chk("t4_missed", int'(missed), 4'b0010);
    chk("t4_pending_kept", int'(pending), 4'b0010);
    step(1);
    chk("t4_missed_clr", int'(missed), 0);
    wait_idle(ic);

    // Enable gating and parameter capture at grant.
    delay = 4'd0; width = 4'd6; holdoff = 4'd0; enable = 1'b0;
    pulse(4'b0100, c);
    step(3);
    chk("t5_pending", int'(pending), 4'b0100);
    chk("t5_not_busy", int'(busy), 0);
    m = cyc;
    enable = 1'b1;
    push(2, 6, m + 1);
    step(2);
    width = 4'd2;
    wait_idle(ic);

    // Reset mid-gate discards the request and restores channel-0 priority.
    delay = 4'd0; width = 4'd10; holdoff = 4'd0;
    pulse(4'b1000, c);
    step(2);
    chk("t6_in_gate", int'(gate_out), 1);
    pulse(4'b0001, tmp);
    rst = 1'b1;
    step(1);
    chk("t6_rst_gate_out", int'(gate_out), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_pending", int'(pending), 0);
    chk("t6_rst_gate_ch", int'(gate_ch), 0);
    rst = 1'b0; width = 4'd2;
    pulse(4'b0101, c);
    push(0, 2, c + 2); push(2, 2, c + 5);
    wait_idle(ic);
    step(2);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_scheduler.md
Name: gate_scheduler

Overview:
- Shares one programmable gate generator among NCH trigger channels.
- Each channel's trigger is rising-edge detected and latched as a pending request.
- A round-robin arbiter grants one pending channel at a time.
- A sequencer runs the granted request through delay, gate and holdoff phases, and drives the gate output tagged with the channel index.
- Sits between the external signal inputs and downstream gated acquisition logic.

Parameters:
- NCH, 4, number of trigger channels (2..16)
- CW, 4, width of the delay, width and holdoff counters/inputs
- CHW, $clog2(NCH), channel index width (derived, not overridable)

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous active-high reset
- trig  in  NCH  raw per-channel trigger levels, already synchronous to clk
- enable  in  1  when 0, no new grants are issued
- delay  in  CW  cycles between grant and gate start
- width  in  CW  gate length in cycles; 0 is treated as 1
- holdoff  in  CW  dead cycles after the gate before the next grant
- gate_out  out  1  gate active
- gate_ch  out  CHW  index of the channel owning the current or last gate
- busy  out  1  sequencer not in IDLE
- pending  out  NCH  latched, not-yet-granted requests
- missed  out  NCH  1-cycle pulse: edge arrived on a channel already pending

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - trig_q, pending, missed, gate_out, busy, gate_ch all 0.
  - state=IDLE, counters 0.
  - rr_ptr=NCH-1, so channel 0 has first priority.
  - Reset mid-gate: gate_out is 0 after that edge, and the in-flight request is discarded.
- Edge detect: trig_q<=trig; edge[i]=trig[i]&~trig_q[i]. A trigger held high through reset produces one edge after reset release.
- Pending latch:
  - edge[i] sets pending[i].
  - A grant to channel i clears pending[i].
  - Edge and grant on the same channel in the same cycle: set wins, pending stays 1, no miss.
  - Edge while pending[i]=1 and channel i not granted that cycle: missed[i]=1 for one cycle; pending unchanged.
- Arbitration: in IDLE with enable=1 and pending!=0, grant the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NCH. On grant: rr_ptr<=grant index, gate_ch<=grant index.
- Parameter capture: delay, width (0 becomes 1) and holdoff are captured at the grant edge. Later changes do not affect the request in flight.
- FSM states: IDLE, DELAY, GATE, HOLDOFF.
  - IDLE: on grant, go to DELAY if delay!=0, else GATE.
  - DELAY: stays exactly delay cycles, then GATE.
  - GATE: stays exactly width cycles, then HOLDOFF if holdoff!=0, else IDLE.
  - HOLDOFF: stays exactly holdoff cycles, then IDLE.
  - IDLE always lasts at least 1 cycle, so consecutive gates are separated by at least holdoff+1 low cycles.
- Output decode: gate_out=(state==GATE); busy=(state!=IDLE). Both are decoded from registered state, with no combinational path from trig.
- Latency: trig rises before edge E0, so pending is set after E0 and the grant happens at E1. gate_out rises after edge E1+delay and stays high width cycles.
- enable=0: edges are still latched. An in-flight sequence completes. Grants resume on the first IDLE cycle with enable=1.
- Counters are CW bits and count down from the captured value. No wrap: a loaded value of 2^CW-1 gives exactly that many cycles.

Decomposition:
- Package gate_sched_pkg holds:
  - the state enum (IDLE, DELAY, GATE, HOLDOFF)
  - the default CW
  - a function that maps width 0 to 1
- Sub-module rr_arbiter:
  - purely combinational
  - inputs: req[NCH], ptr[CHW]
  - outputs: gnt_valid, gnt_idx[CHW]
- gate_scheduler contains the edge detect, pending register, FSM and counters.

Test Plan:
- rst, then pulse trig[2] with delay=3, width=4, holdoff=2 -> pending[2] set, gate_out high exactly 4 cycles starting 4 cycles after the pending edge, gate_ch=2, busy low 2 cycles after the gate ends.
- trig[0], trig[1] and trig[3] rise on the same cycle, delay=0, width=1, holdoff=0 -> gates issued in order ch0, ch1, ch3, each 1 cycle, separated by 1 IDLE cycle.
- width=0 -> 1-cycle gate. delay=15, width=15 -> exactly 15 cycles each (no wrap).
- During a gate for ch1, pulse trig[1] twice -> first pulse re-pends ch1, second pulse gives missed[1] high for 1 cycle, then ch1 is served once more.
- enable=0 while trig[2] pulses -> no grant, pending[2]=1. Raise enable -> grant on the next IDLE cycle. Change width mid-gate -> the current gate keeps the captured width.
- Assert rst during GATE -> gate_out, busy and pending are 0 after that edge. The next request after reset is served channel-0-first.
